// File: rtl/program_loader.sv
// Byte-stream program loader: parses load/run frames, writes 32-bit words into the
// processor memories and runs it. Optional run watchdog enabled by LOADER_WATCHDOG_EN.
module program_loader #(
    parameter int ADDR_W = 10
`ifdef LOADER_WATCHDOG_EN
    , parameter int WDT_CYCLES = 4096
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_byte,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_addr,
    output logic              ins_we,
    output logic [31:0]       data,
    output logic [ADDR_W-1:0] data_addr,
    output logic              data_we,
    output logic              proc_rst,
    input  logic              proc_done,
    input  logic [31:0]       proc_out,
    output logic [31:0]       result,
    output logic              result_valid,
    output logic              busy,
    output logic              error
`ifdef LOADER_WATCHDOG_EN
    , output logic            wdt_trip
`endif
);

    typedef enum logic [3:0] {
        ST_HDR = 4'd0, ST_AH  = 4'd1, ST_AL  = 4'd2, ST_CH  = 4'd3, ST_CL  = 4'd4,
        ST_PAY = 4'd5, ST_WR  = 4'd6, ST_RUN = 4'd7, ST_CAP = 4'd8, ST_ERR = 4'd9
    } state_t;

    localparam logic [16:0] MEM_WORDS = 17'(1 << ADDR_W);

    state_t              state_r, state_s;
    logic                cmd_instr_r;
    logic [7:0]          addr_hi_r, cnt_hi_r;
    logic [15:0]         wr_addr_r, words_left_r;
    logic [23:0]         shift_r;
    logic [1:0]          byte_cnt_r;
    logic                run_armed_r;
    logic                in_ready_r, in_ready_s;
    logic                proc_rst_r, proc_rst_s;
    logic                busy_r, busy_s, error_r, error_s;
    logic                ins_we_r, ins_we_s, data_we_r, data_we_s;
    logic [31:0]         instr_r, data_r, result_r;
    logic [ADDR_W-1:0]   instr_addr_r, data_addr_r;
    logic                result_valid_r;
    logic                accept_s;
    logic [15:0]         addr_full_s, cnt_full_s;
    logic [16:0]         end_s;
    logic [31:0]         word_s;
    logic                done_seen_s;
`ifdef LOADER_WATCHDOG_EN
    logic [31:0]         wdt_cnt_r;
    logic                wdt_trip_r, wdt_trip_s;
    logic                wdt_expired_s;
`endif

    assign accept_s    = in_valid && in_ready_r;
    assign addr_full_s = {addr_hi_r, in_byte};
    assign cnt_full_s  = {cnt_hi_r, in_byte};
    assign end_s       = {1'b0, wr_addr_r} + {1'b0, cnt_full_s};
    assign word_s      = {shift_r, in_byte};
    // proc_done on the RUN entry cycle may be stale, so it only counts once armed.
    assign done_seen_s = run_armed_r && proc_done;
`ifdef LOADER_WATCHDOG_EN
    assign wdt_expired_s = (wdt_cnt_r == 32'(WDT_CYCLES - 1));
`endif

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_HDR: begin
                if (accept_s) begin
                    case (in_byte)
                        8'h01, 8'h02: state_s = ST_AH;
                        8'h03:        state_s = ST_RUN;
                        default:      state_s = ST_ERR;
                    endcase
                end else begin
                    state_s = ST_HDR;
                end
            end
            ST_AH: begin
                if (accept_s) state_s = ST_AL;
                else          state_s = ST_AH;
            end
            ST_AL: begin
                if (accept_s && ({1'b0, addr_full_s} >= MEM_WORDS)) state_s = ST_ERR;
                else if (accept_s)                                  state_s = ST_CH;
                else                                                state_s = ST_AL;
            end
            ST_CH: begin
                if (accept_s) state_s = ST_CL;
                else          state_s = ST_CH;
            end
            ST_CL: begin
                if (accept_s && (end_s > MEM_WORDS))      state_s = ST_ERR;
                else if (accept_s && cnt_full_s == 16'd0) state_s = ST_HDR;
                else if (accept_s)                        state_s = ST_PAY;
                else                                      state_s = ST_CL;
            end
            ST_PAY: begin
                if (accept_s && byte_cnt_r == 2'd3) state_s = ST_WR;
                else                                state_s = ST_PAY;
            end
            ST_WR: begin
                if (words_left_r == 16'd0) state_s = ST_HDR;
                else                       state_s = ST_PAY;
            end
            ST_RUN: begin
                if (done_seen_s)        state_s = ST_CAP;
`ifdef LOADER_WATCHDOG_EN
                else if (wdt_expired_s) state_s = ST_ERR;
`endif
                else                    state_s = ST_RUN;
            end
            ST_CAP:  state_s = ST_HDR;
            ST_ERR:  state_s = ST_ERR;
            default: state_s = ST_ERR;
        endcase
    end

    // Output decode for the state being entered; registered below.
    always_comb begin
        in_ready_s = (state_s == ST_HDR) || (state_s == ST_AH) || (state_s == ST_AL) ||
                     (state_s == ST_CH)  || (state_s == ST_CL) || (state_s == ST_PAY);
        proc_rst_s = (state_s != ST_RUN);
        busy_s     = (state_s != ST_HDR);
        error_s    = (state_s == ST_ERR);
        ins_we_s   = (state_s == ST_WR) && cmd_instr_r;
        data_we_s  = (state_s == ST_WR) && !cmd_instr_r;
`ifdef LOADER_WATCHDOG_EN
        wdt_trip_s = (state_r == ST_RUN) && (state_s == ST_ERR);
`endif
    end

    // State register and registered control outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_HDR;
            in_ready_r <= 1'b1;
            proc_rst_r <= 1'b1;
            busy_r     <= 1'b0;
            error_r    <= 1'b0;
            ins_we_r   <= 1'b0;
            data_we_r  <= 1'b0;
`ifdef LOADER_WATCHDOG_EN
            wdt_trip_r <= 1'b0;
`endif
        end else begin
            state_r    <= state_s;
            in_ready_r <= in_ready_s;
            proc_rst_r <= proc_rst_s;
            busy_r     <= busy_s;
            error_r    <= error_s;
            ins_we_r   <= ins_we_s;
            data_we_r  <= data_we_s;
`ifdef LOADER_WATCHDOG_EN
            wdt_trip_r <= wdt_trip_s;
`endif
        end
    end

    // Frame fields, word assembly, write ports and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_instr_r    <= 1'b0;
            addr_hi_r      <= 8'd0;
            cnt_hi_r       <= 8'd0;
            wr_addr_r      <= 16'd0;
            words_left_r   <= 16'd0;
            shift_r        <= 24'd0;
            byte_cnt_r     <= 2'd0;
            run_armed_r    <= 1'b0;
            instr_r        <= 32'd0;
            data_r         <= 32'd0;
            instr_addr_r   <= '0;
            data_addr_r    <= '0;
            result_r       <= 32'd0;
            result_valid_r <= 1'b0;
`ifdef LOADER_WATCHDOG_EN
            wdt_cnt_r      <= 32'd0;
`endif
        end else begin
            case (state_r)
                ST_HDR: begin
                    run_armed_r <= 1'b0;
`ifdef LOADER_WATCHDOG_EN
                    wdt_cnt_r   <= 32'd0;
`endif
                    if (accept_s) cmd_instr_r <= (in_byte == 8'h01);
                    if (state_s == ST_RUN) result_valid_r <= 1'b0;
                end
                ST_AH: if (accept_s) addr_hi_r <= in_byte;
                ST_AL: if (accept_s) wr_addr_r <= addr_full_s;
                ST_CH: if (accept_s) cnt_hi_r <= in_byte;
                ST_CL: begin
                    if (accept_s) begin
                        words_left_r <= cnt_full_s;
                        byte_cnt_r   <= 2'd0;
                    end
                end
                ST_PAY: begin
                    if (accept_s) begin
                        shift_r    <= {shift_r[15:0], in_byte};
                        byte_cnt_r <= byte_cnt_r + 2'd1;
                        if (byte_cnt_r == 2'd3) begin
                            words_left_r <= words_left_r - 16'd1;
                            if (cmd_instr_r) begin
                                instr_r      <= word_s;
                                instr_addr_r <= wr_addr_r[ADDR_W-1:0];
                            end else begin
                                data_r      <= word_s;
                                data_addr_r <= wr_addr_r[ADDR_W-1:0];
                            end
                        end
                    end
                end
                ST_WR: wr_addr_r <= wr_addr_r + 16'd1;
                ST_RUN: begin
                    run_armed_r <= 1'b1;
`ifdef LOADER_WATCHDOG_EN
                    wdt_cnt_r   <= wdt_cnt_r + 32'd1;
`endif
                end
                ST_CAP: begin
                    result_r       <= proc_out;
                    result_valid_r <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // in_ready and proc_rst also react during the reset cycle itself.
    assign in_ready     = in_ready_r && !rst;
    assign proc_rst     = proc_rst_r || rst;
    assign busy         = busy_r;
    assign error        = error_r;
    assign ins_we       = ins_we_r;
    assign data_we      = data_we_r;
    assign instr        = instr_r;
    assign data         = data_r;
    assign instr_addr   = instr_addr_r;
    assign data_addr    = data_addr_r;
    assign result       = result_r;
    assign result_valid = result_valid_r;
`ifdef LOADER_WATCHDOG_EN
    assign wdt_trip     = wdt_trip_r;
`endif

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: frame-level reference model, processor stub,
// write monitor. Watchdog case is built only with LOADER_WATCHDOG_EN.
module tb_program_loader;
    localparam int ADDR_W = 10;
    localparam int MEMW   = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst, in_valid, in_ready, ins_we, data_we, proc_rst, proc_done;
    logic [7:0]        in_byte;
    logic [31:0]       instr, data, proc_out, result;
    logic [ADDR_W-1:0] instr_addr, data_addr;
    logic              result_valid, busy, error;
`ifdef LOADER_WATCHDOG_EN
    logic              wdt_trip;
`endif

    always #5 clk = ~clk;

`ifdef LOADER_WATCHDOG_EN
    program_loader #(.ADDR_W(ADDR_W), .WDT_CYCLES(50)) dut (
`else
    program_loader #(.ADDR_W(ADDR_W)) dut (
`endif
        .clk(clk), .rst(rst), .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .instr_addr(instr_addr), .ins_we(ins_we),
        .data(data), .data_addr(data_addr), .data_we(data_we),
        .proc_rst(proc_rst), .proc_done(proc_done), .proc_out(proc_out),
        .result(result), .result_valid(result_valid), .busy(busy), .error(error)
`ifdef LOADER_WATCHDOG_EN
        , .wdt_trip(wdt_trip)
`endif
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        is_instr;
        logic [31:0] addr;
        logic [31:0] word;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         obs_q[$];
    logic [31:0] model_dmem [MEMW];
    logic [31:0] stub_dmem  [MEMW];
    logic [31:0] frame_w    [16];
    int          run_cnt = 0;
    int          stub_lat = 1;
    logic        force_done;
    int          trip_cnt = 0;

    // Processor stub: adds data words 0 and 1; done after stub_lat cycles out of reset.
    assign proc_out  = stub_dmem[0] + stub_dmem[1];
    assign proc_done = force_done || (!proc_rst && run_cnt >= stub_lat);

    always @(posedge clk) begin
        if (proc_rst) run_cnt <= 0;
        else          run_cnt <= run_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Write monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (ins_we || data_we) begin
                check("we_in_ready", {31'd0, in_ready}, 32'd0);
                check("we_onehot", {31'd0, ins_we && data_we}, 32'd0);
                if (ins_we) obs_q.push_back('{1'b1, 32'(instr_addr), instr});
                else        obs_q.push_back('{1'b0, 32'(data_addr), data});
                if (data_we) stub_dmem[data_addr] <= data;
            end
`ifdef LOADER_WATCHDOG_EN
            if (wdt_trip) trip_cnt <= trip_cnt + 1;
`endif
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int w;
        if (gaps) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end
        in_byte  = b;
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 200) begin @(posedge clk); #1; w++; end
        check("in_ready_wait", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic compare_writes();
        check("wr_count", 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            check("wr_kind", {31'd0, obs_q[i].is_instr}, {31'd0, exp_q[i].is_instr});
            check("wr_addr", obs_q[i].addr, exp_q[i].addr);
            check("wr_data", obs_q[i].word, exp_q[i].word);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    // Reference: frame semantics in plain arithmetic; returns whether ERR is expected.
    task automatic load_frame(input logic [7:0] cmd, input int start, input int n,
                              input bit gaps, output bit exp_err);
        exp_err = 1'b0;
        send_byte(cmd, gaps);
        send_byte(8'(start >> 8), gaps);
        send_byte(8'(start), gaps);
        if (start >= MEMW) exp_err = 1'b1;
        if (!exp_err) begin
            send_byte(8'(n >> 8), gaps);
            send_byte(8'(n), gaps);
            if (start + n > MEMW) exp_err = 1'b1;
        end
        if (!exp_err) begin
            for (int i = 0; i < n; i++) begin
                for (int k = 3; k >= 0; k--) send_byte(8'(frame_w[i] >> (8 * k)), gaps);
                exp_q.push_back('{cmd == 8'h01, 32'(start + i), frame_w[i]});
                if (cmd == 8'h02) model_dmem[start + i] = frame_w[i];
            end
        end
        repeat (3) begin @(posedge clk); #1; end
        compare_writes();
        check("frame_error", {31'd0, error}, {31'd0, exp_err});
        check("frame_busy", {31'd0, busy}, {31'd0, exp_err});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_proc_rst", {31'd0, proc_rst}, 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_in_ready", {31'd0, in_ready}, 32'd1);
        check("post_busy", {31'd0, busy}, 32'd0);
        check("post_error", {31'd0, error}, 32'd0);
        check("post_we", {30'd0, ins_we, data_we}, 32'd0);
        check("post_rv", {31'd0, result_valid}, 32'd0);
        check("post_words", instr | data | result, 32'd0);
        check("post_addrs", 32'(instr_addr) | 32'(data_addr), 32'd0);
        check("post_proc_rst", {31'd0, proc_rst}, 32'd1);
    endtask

    // Send RUN; returns the number of cycles proc_rst was low.
    task automatic do_run(input int lat, input bit force_d, output int low);
        stub_lat   = lat;
        force_done = force_d;
        send_byte(8'h03, 1'b0);
        check("run_rv_clear", {31'd0, result_valid}, 32'd0);
        low = 0;
        while (proc_rst == 1'b0 && low < 5000) begin low++; @(posedge clk); #1; end
        force_done = 1'b0;
    endtask

    task automatic run_and_check(input int lat, input bit force_d);
        int low, exp_low;
        do_run(lat, force_d, low);
        exp_low = force_d ? 2 : ((lat + 1 > 2) ? lat + 1 : 2);
        check("run_len", 32'(low), 32'(exp_low));
        @(posedge clk); #1;
        check("result", result, model_dmem[0] + model_dmem[1]);
        check("result_valid", {31'd0, result_valid}, 32'd1);
        check("run_proc_rst", {31'd0, proc_rst}, 32'd1);
        check("run_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        bit e;
        rst = 1'b1; in_valid = 1'b0; in_byte = 8'd0; force_done = 1'b0;
        for (int i = 0; i < MEMW; i++) begin model_dmem[i] = 32'd0; stub_dmem[i] = 32'd0; end
        do_reset();

        // Data load of 5 and 10 at 0..1; outputs hold afterwards.
        frame_w[0] = 32'd5; frame_w[1] = 32'd10;
        load_frame(8'h02, 0, 2, 1'b0, e);
        check("hold_data_addr", 32'(data_addr), 32'd1);
        check("hold_data", data, 32'd10);

        // Program load then run.
        frame_w[0] = 32'h8C080000; frame_w[1] = 32'h8C090001; frame_w[2] = 32'h01095020;
        frame_w[3] = 32'hAC0A0002; frame_w[4] = 32'hFC000000;
        load_frame(8'h01, 0, 5, 1'b0, e);
        run_and_check(3, 1'b0);

        // Bounds errors, then bad header code.
        load_frame(8'h01, 16'h03FF, 2, 1'b0, e);
        check("bounds_in_ready", {31'd0, in_ready}, 32'd0);
        do_reset();
        load_frame(8'h01, 16'h0400, 1, 1'b0, e);
        do_reset();
        send_byte(8'h07, 1'b0);
        check("bad_hdr_error", {31'd0, error}, 32'd1);
        do_reset();

        // Last-word boundary and a count-0 frame.
        frame_w[0] = 32'hDEADBEEF;
        load_frame(8'h02, MEMW - 1, 1, 1'b1, e);
        load_frame(8'h01, 100, 0, 1'b1, e);

        // Backpressure gaps, done held high on RUN entry.
        frame_w[0] = 32'd5; frame_w[1] = 32'd10;
        load_frame(8'h02, 0, 2, 1'b1, e);
        run_and_check(0, 1'b1);

        // Randomized frames against the model.
        for (int it = 0; it < 10; it++) begin
            int n, start, mode;
            logic [7:0] cmd;
            cmd  = ($urandom_range(0, 1) == 0) ? 8'h01 : 8'h02;
            n    = $urandom_range(0, 4);
            mode = $urandom_range(0, 3);
            if (mode == 0)      start = MEMW - n + $urandom_range(1, 3);
            else if (mode == 1) start = $urandom_range(MEMW, 65535);
            else                start = $urandom_range(0, 1) ? $urandom_range(0, 2) : $urandom_range(0, MEMW - n);
            for (int i = 0; i < n; i++) frame_w[i] = $urandom;
            load_frame(cmd, start, n, 1'b1, e);
            if (e) do_reset();
        end
        run_and_check($urandom_range(1, 20), 1'b0);

        // Reset after two payload bytes: nothing written, clean frame afterwards.
        send_byte(8'h02, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0); send_byte(8'h01, 1'b0);
        send_byte(8'hAA, 1'b0); send_byte(8'hBB, 1'b0);
        do_reset();
        repeat (3) begin @(posedge clk); #1; end
        compare_writes();
        frame_w[0] = 32'h12345678; frame_w[1] = 32'h00000001;
        load_frame(8'h02, 0, 2, 1'b1, e);
        run_and_check(2, 1'b0);

`ifdef LOADER_WATCHDOG_EN
        begin
            int low;
            logic [31:0] prev;
            prev = result;
            do_run(1000000, 1'b0, low);
            check("wdt_len", 32'(low), 32'd50);
            @(posedge clk); #1;
            check("wdt_error", {31'd0, error}, 32'd1);
            check("wdt_proc_rst", {31'd0, proc_rst}, 32'd1);
            check("wdt_result", result, prev);
            check("wdt_pulses", 32'(trip_cnt), 32'd1);
            do_reset();
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
